writeback_ctrl: RTL and testbench

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/wb_regfile.sv | 32 +++
 rtl/writeback_ctrl.sv | 178 +++++++++++++++++
 tb/tb_writeback_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, writeback condition codes, controller
// states and cpu_status encodings.
package cpu_pkg;

    localparam logic [4:0] OPC_NOP  = 5'd0;
    localparam logic [4:0] OPC_LOAD = 5'd1;
    localparam logic [4:0] OPC_ADD  = 5'd2;

    localparam logic [2:0] COND_NEVER  = 3'd0;
    localparam logic [2:0] COND_ALWAYS = 3'd1;
    localparam logic [2:0] COND_Z      = 3'd2;
    localparam logic [2:0] COND_NZ     = 3'd3;
    localparam logic [2:0] COND_GE     = 3'd4;
    localparam logic [2:0] COND_LT     = 3'd5;

    localparam logic [7:0] CPU_ST_RUN   = 8'h01;
    localparam logic [7:0] CPU_ST_FLUSH = 8'h02;
    localparam logic [7:0] CPU_ST_HALT  = 8'h04;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Z lives in status[0], LT in status[2]; codes 6/7 never fire.
    function automatic logic cond_true(input logic [2:0] cond, input logic [7:0] status);
        logic ok;
        ok = 1'b0;
        case (cond)
            COND_ALWAYS: ok = 1'b1;
            COND_Z:      ok = status[0];
            COND_NZ:     ok = ~status[0];
            COND_GE:     ok = ~status[2];
            COND_LT:     ok = status[2];
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// General-purpose register file: NREGS entries, two async reads, one sync
// write; indices at or above NREGS read as zero and ignore writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int RIDX_W = 4,
    parameter int NREGS  = 14
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_we,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RIDX_W-1:0] i_ra_a,
    input  logic [RIDX_W-1:0] i_ra_b,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (nRst) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (i_we && (int'(i_waddr) < NREGS)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rd_a = (int'(i_ra_a) < NREGS) ? r_regs[i_ra_a] : '0;
    assign o_rd_b = (int'(i_ra_b) < NREGS) ? r_regs[i_ra_b] : '0;

endmodule

// File: rtl/writeback_ctrl.sv
// Writeback stage controller: register/PC/OVF writes, hazard stall, flush/halt FSM.
// Define WRITEBACK_CTRL_FORWARD_EN to replace RAW stalls with a registered forward path.
module writeback_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RIDX_W    = 4,
    parameter int PC_W      = 12,
    parameter int FLUSH_CYC = 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              wb_valid,
    input  logic [4:0]        wb_opc,
    input  logic [RIDX_W-1:0] wb_rc,
    input  logic [2:0]        wb_cond,
    input  logic              wb_cmp,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] alu_ovf,
    input  logic [7:0]        alu_status,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ex_valid,
    input  logic [RIDX_W-1:0] ex_ra,
    input  logic [RIDX_W-1:0] ex_rb,
    input  logic              ex_imb,
    input  logic              halt_req,
    input  logic [RIDX_W-1:0] rd_a,
    input  logic [RIDX_W-1:0] rd_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        fwd_en,
    output logic              stall,
    output logic              flush,
    output logic [PC_W-1:0]   pc,
    output logic [7:0]        cpu_status
);

    localparam int                NREGS      = (1 << RIDX_W) - 2;
    localparam logic [RIDX_W-1:0] PC_IDX     = RIDX_W'(NREGS);
    localparam logic [RIDX_W-1:0] OVF_IDX    = RIDX_W'(NREGS + 1);
    localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYC - 1);

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_flush_cnt, w_flush_cnt_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_ovf;
    logic [7:0]        r_status;

    logic              w_run, w_we, w_pc_wr, w_ovf_wr, w_raw, w_ra_hz, w_rb_hz;
    logic [DATA_W-1:0] w_wval, w_rf_a, w_rf_b;

    assign w_run    = (r_state == ST_RUN);
    assign w_we     = w_run && wb_valid &&
                      ((wb_opc == OPC_LOAD) || ((wb_opc != OPC_NOP) && cond_true(wb_cond, r_status)));
    assign w_wval   = (wb_opc == OPC_LOAD) ? mem_rdata : alu_res;
    assign w_pc_wr  = w_we && (wb_rc == PC_IDX);
    assign w_ovf_wr = w_we && (wb_rc == OVF_IDX);
    assign w_ra_hz  = (ex_ra == PC_IDX) || (ex_ra == OVF_IDX);
    assign w_rb_hz  = !ex_imb && ((ex_rb == PC_IDX) || (ex_rb == OVF_IDX));

`ifdef WRITEBACK_CTRL_FORWARD_EN
    logic [DATA_W-1:0] r_fwd_data;
    logic [1:0]        r_fwd_en;

    assign w_raw = 1'b0;

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_fwd_data <= '0;
            r_fwd_en   <= '0;
        end else begin
            r_fwd_data <= w_wval;
            if (!w_we)                              r_fwd_en <= 2'b00;
            else if (ex_ra == wb_rc)                r_fwd_en <= 2'b01;
            else if (!ex_imb && (ex_rb == wb_rc))   r_fwd_en <= 2'b10;
            else                                    r_fwd_en <= 2'b00;
        end
    end

    assign fwd_data = r_fwd_data;
    assign fwd_en   = r_fwd_en;
`else
    assign w_raw    = w_we && ((ex_ra == wb_rc) || (!ex_imb && (ex_rb == wb_rc)));
    assign fwd_data = '0;
    assign fwd_en   = '0;
`endif

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        stall           = 1'b0;
        flush           = 1'b0;
        cpu_status      = CPU_ST_FLUSH;
        case (r_state)
            ST_FLUSH: begin
                flush = 1'b1;
                if (r_flush_cnt == 3'd0) w_state_nxt = ST_RUN;
                else                     w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            end
            ST_RUN: begin
                cpu_status = CPU_ST_RUN;
                stall = ex_valid && (w_ra_hz || w_rb_hz || (wb_cmp && w_we) || w_raw);
                // halt wins over the flush a PC write would otherwise start
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (w_pc_wr) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            ST_HALT: begin
                cpu_status = CPU_ST_HALT;
                stall      = 1'b1;
            end
            default: w_state_nxt = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            r_pc     <= '0;
            r_ovf    <= '0;
            r_status <= '0;
        end else if (w_run) begin
            if (w_pc_wr)     r_pc <= w_wval[PC_W-1:0];
            else if (!stall) r_pc <= r_pc + 1'b1;

            if (w_ovf_wr)
                r_ovf <= w_wval;
            else if (wb_valid && (wb_opc != OPC_LOAD) && (wb_rc != OVF_IDX))
                r_ovf <= alu_ovf;

            if (wb_valid && wb_cmp) r_status <= alu_status;
        end
    end

    wb_regfile #(
        .DATA_W (DATA_W),
        .RIDX_W (RIDX_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .nRst    (nRst),
        .i_we    (w_we),
        .i_waddr (wb_rc),
        .i_wdata (w_wval),
        .i_ra_a  (rd_a),
        .i_ra_b  (rd_b),
        .o_rd_a  (w_rf_a),
        .o_rd_b  (w_rf_b)
    );

    always_comb begin
        rd_data_a = w_rf_a;
        if (rd_a == PC_IDX)       rd_data_a = DATA_W'(r_pc);
        else if (rd_a == OVF_IDX) rd_data_a = r_ovf;
    end

    always_comb begin
        rd_data_b = w_rf_b;
        if (rd_b == PC_IDX)       rd_data_b = DATA_W'(r_pc);
        else if (rd_b == OVF_IDX) rd_data_b = r_ovf;
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl with FLUSH_CYC=2; expectations follow the
// WRITEBACK_CTRL_FORWARD_EN setting of the build.
module tb_writeback_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        nRst;
    logic        wb_valid, wb_cmp, ex_valid, ex_imb, halt_req;
    logic [4:0]  wb_opc;
    logic [3:0]  wb_rc, ex_ra, ex_rb, rd_a, rd_b;
    logic [2:0]  wb_cond;
    logic [31:0] alu_res, alu_ovf, mem_rdata, rd_data_a, rd_data_b, fwd_data;
    logic [7:0]  alu_status, cpu_status;
    logic [1:0]  fwd_en;
    logic        stall, flush;
    logic [11:0] pc;
    logic [11:0] exp_pc;

    int n_vec = 0;
    int n_err = 0;

    writeback_ctrl #(
        .DATA_W    (32),
        .RIDX_W    (4),
        .PC_W      (12),
        .FLUSH_CYC (2)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .wb_valid   (wb_valid),
        .wb_opc     (wb_opc),
        .wb_rc      (wb_rc),
        .wb_cond    (wb_cond),
        .wb_cmp     (wb_cmp),
        .alu_res    (alu_res),
        .alu_ovf    (alu_ovf),
        .alu_status (alu_status),
        .mem_rdata  (mem_rdata),
        .ex_valid   (ex_valid),
        .ex_ra      (ex_ra),
        .ex_rb      (ex_rb),
        .ex_imb     (ex_imb),
        .halt_req   (halt_req),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .fwd_data   (fwd_data),
        .fwd_en     (fwd_en),
        .stall      (stall),
        .flush      (flush),
        .pc         (pc),
        .cpu_status (cpu_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_opc = OPC_NOP; wb_rc = 0; wb_cond = COND_NEVER; wb_cmp = 0;
        alu_res = 0; alu_ovf = 0; alu_status = 0; mem_rdata = 0;
        ex_valid = 0; ex_ra = 0; ex_rb = 0; ex_imb = 0; halt_req = 0;
    endtask

    task automatic wb(input logic [4:0] opc, input logic [3:0] rc, input logic [2:0] cond,
                      input logic [31:0] val);
        wb_valid = 1; wb_opc = opc; wb_rc = rc; wb_cond = cond;
        alu_res = val; mem_rdata = val;
    endtask

    initial begin
        idle();
        rd_a = 0; rd_b = 0;
        nRst = 1;
        tick(); tick();
        rd_a = 4'd3;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_status", 32'(cpu_status), 32'h02);
        chk("rst_flush", 32'(flush), 32'h1);
        chk("rst_fwd_en", 32'(fwd_en), 32'h0);

        nRst = 0;
        #1 chk("flush_c1", 32'(flush), 32'h1);
        tick();
        chk("flush_c2", 32'(flush), 32'h1);
        tick();
        chk("run_status", 32'(cpu_status), 32'h01);
        chk("run_flush", 32'(flush), 32'h0);
        chk("run_pc0", 32'(pc), 32'h0);
        exp_pc = 12'h0;

        // cmp with Z=1, then conditional ADD on Z
        wb(OPC_NOP, 4'd0, COND_NEVER, 0); wb_cmp = 1; alu_status = 8'h01;
        tick(); exp_pc++;
        idle(); wb(OPC_ADD, 4'd3, COND_Z, 32'h55);
        tick(); exp_pc++;
        idle(); rd_a = 4'd3;
        #1 chk("cond_z_write", rd_data_a, 32'h55);
        // cmp with Z=0: same write must not happen, NZ must
        wb(OPC_NOP, 4'd0, COND_NEVER, 0); wb_cmp = 1; alu_status = 8'h00;
        tick(); exp_pc++;
        idle(); wb(OPC_ADD, 4'd3, COND_Z, 32'hAA);
        tick(); exp_pc++;
        idle(); wb(OPC_ADD, 4'd4, COND_NZ, 32'h66);
        tick(); exp_pc++;
        idle(); rd_a = 4'd3; rd_b = 4'd4;
        #1 chk("cond_z_skip", rd_data_a, 32'h55);
        chk("cond_nz_write", rd_data_b, 32'h66);
        chk("pc_run5", 32'(pc), 32'(exp_pc));

        // RAW on A: ADD r5=7 while ex reads r5
        wb(OPC_ADD, 4'd5, COND_ALWAYS, 32'h7); ex_valid = 1; ex_ra = 4'd5; ex_imb = 1;
        #1;
`ifdef WRITEBACK_CTRL_FORWARD_EN
        chk("raw_a_stall", 32'(stall), 32'h0);
        tick(); exp_pc++;
        chk("fwd_a_en", 32'(fwd_en), 32'h1);
        chk("fwd_a_data", fwd_data, 32'h7);
`else
        chk("raw_a_stall", 32'(stall), 32'h1);
        tick();
        chk("fwd_a_en", 32'(fwd_en), 32'h0);
`endif
        idle(); rd_a = 4'd5;
        #1 chk("r5_written", rd_data_a, 32'h7);
        chk("pc_raw_a", 32'(pc), 32'(exp_pc));

        // RAW on non-immediate B
        wb(OPC_ADD, 4'd6, COND_ALWAYS, 32'h9); ex_valid = 1; ex_ra = 4'd1; ex_rb = 4'd6; ex_imb = 0;
        #1;
`ifdef WRITEBACK_CTRL_FORWARD_EN
        chk("raw_b_stall", 32'(stall), 32'h0);
        tick(); exp_pc++;
        chk("fwd_b_en", 32'(fwd_en), 32'h2);
        chk("fwd_b_data", fwd_data, 32'h9);
`else
        chk("raw_b_stall", 32'(stall), 32'h1);
        tick();
        chk("fwd_b_en", 32'(fwd_en), 32'h0);
`endif
        idle();
        tick(); exp_pc++;
        chk("fwd_clear", 32'(fwd_en), 32'h0);

        // OVF hazard on Rb, then the same index as immediate
        ex_valid = 1; ex_rb = 4'd15; ex_imb = 0;
        #1 chk("ovf_hz_stall", 32'(stall), 32'h1);
        tick();
        chk("ovf_hz_pc_held", 32'(pc), 32'(exp_pc));
        ex_imb = 1;
        #1 chk("ovf_imm_nostall", 32'(stall), 32'h0);
        tick(); exp_pc++;
        chk("ovf_imm_pc", 32'(pc), 32'(exp_pc));

        // OVF register: explicit write beats alu_ovf; LOAD leaves it alone
        idle(); wb(OPC_ADD, 4'd15, COND_ALWAYS, 32'h11); alu_ovf = 32'h22;
        tick(); exp_pc++;
        idle(); rd_b = 4'd15;
        #1 chk("ovf_explicit", rd_data_b, 32'h11);
        wb(OPC_ADD, 4'd0, COND_NEVER, 32'h0); alu_ovf = 32'h33;
        tick(); exp_pc++;
        idle();
        #1 chk("ovf_from_alu", rd_data_b, 32'h33);
        wb(OPC_LOAD, 4'd0, COND_NEVER, 32'h44); alu_ovf = 32'h99;
        tick(); exp_pc++;
        idle(); rd_a = 4'd0;
        #1 chk("ovf_load_keep", rd_data_b, 32'h33);
        chk("load_ignores_cond", rd_data_a, 32'h44);

        // cmp together with an enabled write stalls ex
        wb(OPC_ADD, 4'd7, COND_ALWAYS, 32'h1); wb_cmp = 1; ex_valid = 1; ex_ra = 4'd1; ex_imb = 1;
        #1 chk("cmp_stall", 32'(stall), 32'h1);
        tick();
        idle();
        chk("cmp_pc_held", 32'(pc), 32'(exp_pc));

        // branch through LOAD to PC index
        wb(OPC_LOAD, 4'd14, COND_NEVER, 32'h123);
        tick();
        idle();
        chk("br_pc", 32'(pc), 32'h123);
        chk("br_flush1", 32'(flush), 32'h1);
        chk("br_status", 32'(cpu_status), 32'h02);
        tick();
        chk("br_flush2", 32'(flush), 32'h1);
        chk("br_pc_hold", 32'(pc), 32'h123);
        tick();
        rd_a = 4'd14;
        #1 chk("br_run", 32'(cpu_status), 32'h01);
        chk("br_pc_after", 32'(pc), 32'h123);
        chk("rd_pc_zext", rd_data_a, 32'h123);

        // pc wrap
        wb(OPC_LOAD, 4'd14, COND_NEVER, 32'hFFF);
        tick(); idle(); tick(); tick();
        chk("wrap_pre", 32'(pc), 32'hFFF);
        tick();
        chk("wrap_post", 32'(pc), 32'h000);

        // halt coinciding with a PC write
        wb(OPC_ADD, 4'd14, COND_ALWAYS, 32'hABC); halt_req = 1;
        tick();
        idle();
        chk("halt_pc", 32'(pc), 32'hABC);
        chk("halt_status", 32'(cpu_status), 32'h04);
        chk("halt_stall", 32'(stall), 32'h1);
        wb(OPC_LOAD, 4'd2, COND_NEVER, 32'h77);
        tick(); tick(); tick();
        idle(); rd_a = 4'd2;
        #1 chk("halt_no_write", rd_data_a, 32'h0);
        chk("halt_pc_hold", 32'(pc), 32'hABC);
        chk("halt_status_hold", 32'(cpu_status), 32'h04);
        chk("halt_stall_hold", 32'(stall), 32'h1);

        nRst = 1;
        tick();
        rd_a = 4'd3; rd_b = 4'd15;
        #1 chk("rst2_pc", 32'(pc), 32'h0);
        chk("rst2_status", 32'(cpu_status), 32'h02);
        chk("rst2_r3", rd_data_a, 32'h0);
        chk("rst2_ovf", rd_data_b, 32'h0);
        nRst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
